// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d 3x3 datapath control: FSM encoding,
// default image geometry and the window margin.
package conv2d_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2,
      ST_DONE  = 2'd3
   } ctrl_state_e;

   localparam int DEFAULT_IMG_W = 100;
   localparam int DEFAULT_IMG_H = 100;

   // Rows/columns that must already be buffered before a full 3x3 window exists.
   localparam int KERNEL_HALO = 2;

endpackage

// File: rtl/conv_pos_counter.sv
// Raster (row, column) position counter for pixels entering the line buffers.
// Clr restarts at (0,0); Inc advances; the counter parks on the last pixel.
module conv_pos_counter #(
   parameter int IMG_W = 100,
   parameter int IMG_H = 100,
   parameter int COL_W = 7,
   parameter int ROW_W = 7
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Inc,
   input  logic             Clr,
   output logic [ROW_W-1:0] Row,
   output logic [COL_W-1:0] Col,
   output logic             Last
);

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [ROW_W-1:0] row_q, row_d;
   logic [COL_W-1:0] col_q, col_d;
   logic             last;

   assign last = (row_q == ROW_LAST) && (col_q == COL_LAST);

   // Terminal position is held so the FSM sees stable counters through FLUSH.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (Clr) begin
         row_d = '0;
         col_d = '0;
      end else if (Inc && !last) begin
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign Row  = row_q;
   assign Col  = col_q;
   assign Last = last;

endmodule

// File: rtl/conv3x3_window_ctrl.sv
// Frame sequencer for the 3x3 convolution datapath: handshakes pixels in,
// tracks their raster position and flags when a full window is available.
module conv3x3_window_ctrl
   import conv2d_pkg::*;
#(
   parameter int IMG_W = DEFAULT_IMG_W,
   parameter int IMG_H = DEFAULT_IMG_H,
   parameter int COL_W = 7,
   parameter int ROW_W = 7
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Start,
   input  logic             In_Valid,
   output logic             In_Ready,
   output logic             Shift_En,
   input  logic             Out_Ready,
   output logic             Out_Valid,
   output logic [ROW_W-1:0] Out_Row,
   output logic [COL_W-1:0] Out_Col,
   output logic             Busy,
   output logic             Done
);

   localparam logic [ROW_W-1:0] ROW_HALO = ROW_W'(KERNEL_HALO);
   localparam logic [COL_W-1:0] COL_HALO = COL_W'(KERNEL_HALO);

   ctrl_state_e      state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [ROW_W-1:0] out_row_q, out_row_d;
   logic [COL_W-1:0] out_col_q, out_col_d;

   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic             last_pix;
   logic             in_ready;
   logic             shift_en;
   logic             frame_start;
   logic             window_pix;

   // A pending result blocks intake unless downstream takes it this cycle.
   assign in_ready    = (state_q == ST_RUN) && (!out_valid_q || Out_Ready);
   assign shift_en    = In_Valid && in_ready;
   assign frame_start = (state_q == ST_IDLE) && Start;
   assign window_pix  = (row >= ROW_HALO) && (col >= COL_HALO);

   conv_pos_counter #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .COL_W (COL_W),
      .ROW_W (ROW_W)
   ) u_pos (
      .Clk  (Clk),
      .Rst  (Rst),
      .Inc  (shift_en),
      .Clr  (frame_start),
      .Row  (row),
      .Col  (col),
      .Last (last_pix)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (Start) state_d = ST_RUN;
         ST_RUN:   if (shift_en && last_pix) state_d = ST_FLUSH;
         ST_FLUSH: if (!out_valid_q || Out_Ready) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // New window wins over retirement so back-to-back results have no bubble.
   always_comb begin
      out_valid_d = out_valid_q;
      out_row_d   = out_row_q;
      out_col_d   = out_col_q;
      if (shift_en && window_pix) begin
         out_valid_d = 1'b1;
         out_row_d   = row - ROW_W'(1);
         out_col_d   = col - COL_W'(1);
      end else if (out_valid_q && Out_Ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= ST_IDLE;
         out_valid_q <= 1'b0;
         out_row_q   <= '0;
         out_col_q   <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_row_q   <= out_row_d;
         out_col_q   <= out_col_d;
      end
   end

   assign In_Ready  = in_ready;
   assign Shift_En  = shift_en;
   assign Out_Valid = out_valid_q;
   assign Out_Row   = out_row_q;
   assign Out_Col   = out_col_q;
   assign Busy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
   assign Done      = (state_q == ST_DONE);

endmodule

// File: doc/conv3x3_window_ctrl.md
Name: conv3x3_window_ctrl

Overview:
- Sequencing controller for the conv2d3x3 datapath. Tracks the (row, column) position of each pixel streamed into the line buffers, and gates the shift/write enable with a valid/ready handshake.
- Raises output-valid only when a complete 3x3 window lies inside the image, i.e. current row >= 2 and column >= 2.
- Frames a whole image between a Start pulse and a Done pulse. Applies downstream backpressure to the pixel source.

Parameters:
- IMG_W, 100, image width in pixels (>= 3)
- IMG_H, 100, image height in pixels (>= 3)
- COL_W, 7, column counter width; 2^COL_W >= IMG_W
- ROW_W, 7, row counter width; 2^ROW_W >= IMG_H

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- In_Valid  in  1  upstream pixel present
- In_Ready  out  1  controller accepts a pixel this cycle
- Shift_En  out  1  advance line buffers and window registers; equals In_Valid & In_Ready
- Out_Ready  in  1  downstream accepts the window result
- Out_Valid  out  1  datapath output holds a valid 3x3 result
- Out_Row  out  ROW_W  centre row of the valid window (pixel row - 1)
- Out_Col  out  COL_W  centre column of the valid window (pixel col - 1)
- Busy  out  1  high in RUN and FLUSH
- Done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, Rst=0): state IDLE; Row=0, Col=0; Out_Valid=0, Out_Row=0, Out_Col=0, Done=0. In_Ready=0, Shift_En=0, Busy=0. Reset mid-frame abandons the frame and emits no Done.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: Start=1 -> RUN; Row and Col cleared to 0.
  - RUN -> FLUSH on the cycle the last pixel (IMG_H-1, IMG_W-1) is accepted.
  - FLUSH -> DONE when Out_Valid=0, or when Out_Valid & Out_Ready.
  - DONE -> IDLE unconditionally after 1 cycle. Done=1 only in DONE.
- Start is ignored outside IDLE.
- In_Ready (combinational) = (state==RUN) & (!Out_Valid | Out_Ready). Never asserted in IDLE, FLUSH or DONE.
- Accept: a pixel is accepted at a rising edge where Shift_En=1. Counters advance only on accept:
  - Col wraps IMG_W-1 -> 0 and increments Row on the wrap.
  - Row never exceeds IMG_H-1; the last accept leaves the counters at their terminal values until the next Start.
- Window valid: a pixel accepted at (r, c) with r >= 2 and c >= 2 sets Out_Valid=1 on the next edge (latency 1 cycle). On that same edge Out_Row=r-1 and Out_Col=c-1 are registered.
- Border pixels (r < 2 or c < 2) shift the buffers but produce no output. The first column pair of every row is suppressed, not only the first two rows.
- Out_Valid hold: once set, Out_Valid and the Out_Row/Out_Col indices hold stable until Out_Ready=1.
  - Accept with no new window pixel that edge: Out_Valid -> 0.
  - Simultaneous accept plus new window pixel: Out_Valid stays 1 and the indices update (back-to-back, no bubble).
- Throughput: with Out_Ready tied 1 and In_Valid tied 1, one pixel per cycle. A frame takes IMG_W*IMG_H accept cycles plus FLUSH plus DONE.
- Total windows per frame: exactly (IMG_H-2)*(IMG_W-2).
- In_Valid high outside RUN has no effect: no Shift_En, counters unchanged.
- Counter arithmetic is unsigned. Comparisons use full-width constants; no truncation for the legal parameter ranges.

Decomposition:
- Shared package conv2d_pkg: FSM state encoding (2 bits: IDLE=0, RUN=1, FLUSH=2, DONE=3), default IMG_W/IMG_H, and the window-margin constant KERNEL_HALO=2.
- One natural sub-module: conv_pos_counter, holding the Row/Col wrap counter with Inc, Clr and Last outputs. The FSM and the output-valid register stay in the top level.

Test Plan:
- IMG_W=IMG_H=5, Start, In_Valid=1, Out_Ready=1 -> 25 Shift_En pulses. 9 Out_Valid pulses with (Out_Row, Out_Col) = (1,1)..(3,3) in raster order. First Out_Valid appears 1 cycle after pixel (2,2) is accepted. Done pulses once, then IDLE.
- Same frame with Out_Ready held 0 for 4 cycles after the first Out_Valid -> In_Ready=0 throughout. Out_Valid=1 with indices frozen at (1,1); no counter movement. Streaming resumes with no lost or duplicated windows (still 9 total).
- In_Valid toggling 1/0 every cycle -> counters advance only on accepted cycles. Window count 9; Col wraps 4 -> 0 with a Row increment.
- Start asserted during RUN, and In_Valid=1 while IDLE -> both ignored: no Shift_En, Row/Col unchanged, no restart.
- Rst=0 asserted mid-frame at pixel (3,1) -> all outputs are at reset values immediately. No Done. A new Start restarts from (0,0) and completes normally.
- Last window stalled (Out_Ready=0 for 3 cycles after pixel (4,4)) -> FSM stays in FLUSH with Busy=1 and In_Ready=0. DONE is entered on the Out_Ready handshake, and Done=1 for exactly 1 cycle.
